// File: rtl/or8_chk_pkg.sv
// Shared types and defaults for the OR-gate result checker.
package or8_chk_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  // Saturation ceiling for counters at the default width.
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } chk_state_e;

endpackage

// File: rtl/or8_result_checker_if.sv
// Beat stream into the checker: operands, DUT result, valid/ready.
interface or8_result_checker_if #(parameter int WIDTH = or8_chk_pkg::DEF_WIDTH) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_y;

  modport master (output in_valid, in_a, in_b, in_y, input in_ready);
  modport slave  (input in_valid, in_a, in_b, in_y, output in_ready);
endinterface

// File: rtl/or8_chk_pipe.sv
// Two-stage capture/compare pipe: stage 1 holds the beat, stage 2 holds
// the compare verdict and the beat fields for first-failure capture.
module or8_chk_pipe import or8_chk_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             beat_vld,
  input  logic [WIDTH-1:0] beat_a,
  input  logic [WIDTH-1:0] beat_b,
  input  logic [WIDTH-1:0] beat_y,
  input  logic [CNT_W-1:0] beat_idx,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_y,
  output logic [CNT_W-1:0] fail_idx
);
  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;
  logic [WIDTH-1:0] s1_a, s1_b, s1_y;
  logic [CNT_W-1:0] s1_idx;
  logic             s2_mis;

  // Valid shift register; flush drops every beat in flight.
  always_ff @(posedge clk) begin
    if (rst || flush) vld_pipe <= '0;
    else              vld_pipe <= {vld_pipe[STAGES-1:1], beat_vld};
  end

  // Stage 1: hold the accepted beat and its index.
  always_ff @(posedge clk) begin
    if (beat_vld) begin
      s1_a   <= beat_a;
      s1_b   <= beat_b;
      s1_y   <= beat_y;
      s1_idx <= beat_idx;
    end
  end

  // Stage 2: case inequality so X/Z on y is reported as a mismatch.
  always_ff @(posedge clk) begin
    if (vld_pipe[1]) begin
      s2_mis   <= (s1_y !== (s1_a | s1_b));
      fail_a   <= s1_a;
      fail_b   <= s1_b;
      fail_y   <= s1_y;
      fail_idx <= s1_idx;
    end
  end

  assign pass_pulse = vld_pipe[STAGES] & ~s2_mis;
  assign fail_pulse = vld_pipe[STAGES] &  s2_mis;

endmodule

// File: rtl/or8_result_checker.sv
// Hardware scoreboard for the OR-gate stream: FSM, pass/fail counters,
// first-failure capture and done/all_pass reporting.
module or8_result_checker import or8_chk_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_tests,
  or8_result_checker_if.slave  in_if,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 fail_seen,
  output logic [CNT_W-1:0]     fail_idx,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [WIDTH-1:0]     fail_y,
  output logic                 done,
  output logic                 all_pass
);
  localparam logic [CNT_W-1:0] SAT = '1;

  chk_state_e       state, state_nxt;
  logic [CNT_W-1:0] num_reg, accepted;
  logic             drain_cnt;
  logic             in_ready, accept, last_beat;
  logic [CNT_W-1:0] pass_cnt_nxt, fail_cnt_nxt;

  logic             pass_pulse, fail_pulse;
  logic [WIDTH-1:0] p_a, p_b, p_y;
  logic [CNT_W-1:0] p_idx;

  assign in_ready       = (state == RUN) && (accepted < num_reg);
  assign in_if.in_ready = in_ready;
  assign accept         = in_if.in_valid && in_ready;
  assign last_beat      = (accepted == num_reg - CNT_W'(1));

  // A beat accepted on a start edge is flushed along with everything else.
  or8_chk_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_pipe (
    .clk(clk), .rst(rst), .flush(start), .beat_vld(accept),
    .beat_a(in_if.in_a), .beat_b(in_if.in_b), .beat_y(in_if.in_y),
    .beat_idx(accepted),
    .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
    .fail_a(p_a), .fail_b(p_b), .fail_y(p_y), .fail_idx(p_idx)
  );

  // Next state and next counter values; start restarts from any state.
  always_comb begin
    state_nxt    = state;
    pass_cnt_nxt = pass_cnt;
    fail_cnt_nxt = fail_cnt;
    if (start) begin
      state_nxt    = (num_tests == '0) ? REPORT : RUN;
      pass_cnt_nxt = '0;
      fail_cnt_nxt = '0;
    end else begin
      case (state)
        RUN:     if (accept && last_beat) state_nxt = DRAIN;
        DRAIN:   if (drain_cnt)           state_nxt = REPORT;
        default: state_nxt = state;
      endcase
      if (pass_pulse && pass_cnt != SAT) pass_cnt_nxt = pass_cnt + CNT_W'(1);
      if (fail_pulse && fail_cnt != SAT) fail_cnt_nxt = fail_cnt + CNT_W'(1);
    end
  end

  // State, counters, capture and report flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      num_reg   <= '0;
      accepted  <= '0;
      drain_cnt <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_seen <= 1'b0;
      fail_idx  <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_y    <= '0;
      done      <= 1'b0;
      all_pass  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pass_cnt <= pass_cnt_nxt;
      fail_cnt <= fail_cnt_nxt;
      done     <= (state_nxt == REPORT);
      all_pass <= (state_nxt == REPORT) && (fail_cnt_nxt == '0);
      if (start) begin
        num_reg   <= num_tests;
        accepted  <= '0;
        drain_cnt <= 1'b0;
        fail_seen <= 1'b0;
        fail_idx  <= '0;
        fail_a    <= '0;
        fail_b    <= '0;
        fail_y    <= '0;
      end else begin
        if (accept) accepted <= accepted + CNT_W'(1);
        drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        if (fail_pulse && !fail_seen) begin
          fail_seen <= 1'b1;
          fail_idx  <= p_idx;
          fail_a    <= p_a;
          fail_b    <= p_b;
          fail_y    <= p_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_or8_result_checker.sv
// Directed bench for or8_result_checker.
module tb_or8_result_checker;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [CNT_W-1:0] num_tests;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, fail_idx;
  logic             fail_seen, done, all_pass;
  logic [WIDTH-1:0] fail_a, fail_b, fail_y;

  int n_cmp = 0;
  int n_bad = 0;

  or8_result_checker_if #(.WIDTH(WIDTH)) bus ();

  or8_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tests(num_tests), .in_if(bus),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen),
    .fail_idx(fail_idx), .fail_a(fail_a), .fail_b(fail_b), .fail_y(fail_y),
    .done(done), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    bus.in_valid = 1'b0;
    start        = 1'b1;
    num_tests    = n;
    tick();
    start        = 1'b0;
  endtask

  // Present one beat and hold it until the edge that accepts it.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] y);
    int w;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_y     = y;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
    tick();
  endtask

  logic [7:0] t4_a [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [7:0] t4_b [4] = '{8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] t4_y [4] = '{8'h11, 8'h22, 8'h44, 8'h88};
  logic [7:0] t5_a [5] = '{8'h00, 8'hFF, 8'hA5, 8'h0F, 8'h3C};
  logic [7:0] t5_b [5] = '{8'h00, 8'h00, 8'h5A, 8'hF0, 8'hC3};
  logic [7:0] t5_y [5] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    int acc;
    int k;
    rst          = 1'b1;
    start        = 1'b0;
    num_tests    = '0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_y     = '0;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_all_pass", 32'(all_pass), 32'd0);
    chk("rst_fail_seen", 32'(fail_seen), 32'd0);
    rst = 1'b0;
    tick();

    // 1: two passing beats
    do_start(16'd2);
    chk("t1_ready", 32'(bus.in_ready), 32'd1);
    send_beat(8'b00011100, 8'b00010001, 8'b00011101);
    send_beat(8'b10110010, 8'b11110100, 8'b11110110);
    bus.in_valid = 1'b0;
    chk("t1_ready_drop", 32'(bus.in_ready), 32'd0);
    tick();
    chk("t1_done_early", 32'(done), 32'd0);
    tick();
    chk("t1_pass_cnt", 32'(pass_cnt), 32'd2);
    chk("t1_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_all_pass", 32'(all_pass), 32'd1);

    // 2: first failure at index 1 kept, second failure only counted
    do_start(16'd3);
    chk("t2_cleared_done", 32'(done), 32'd0);
    send_beat(8'h0F, 8'h00, 8'h0F);
    send_beat(8'h0F, 8'h00, 8'hFF);
    send_beat(8'h33, 8'h44, 8'h00);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("t2_pass_cnt", 32'(pass_cnt), 32'd1);
    chk("t2_fail_cnt", 32'(fail_cnt), 32'd2);
    chk("t2_fail_seen", 32'(fail_seen), 32'd1);
    chk("t2_fail_idx", 32'(fail_idx), 32'd1);
    chk("t2_fail_a", 32'(fail_a), 32'h0F);
    chk("t2_fail_b", 32'(fail_b), 32'h00);
    chk("t2_fail_y", 32'(fail_y), 32'hFF);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_all_pass", 32'(all_pass), 32'd0);

    // 3: zero-length run reports immediately
    do_start(16'd0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_all_pass", 32'(all_pass), 32'd1);
    chk("t3_ready", 32'(bus.in_ready), 32'd0);
    chk("t3_fail_cnt", 32'(fail_cnt), 32'd0);
    tick();
    chk("t3_ready_hold", 32'(bus.in_ready), 32'd0);

    // 4: valid every other cycle, extra valids after the 4th beat ignored
    do_start(16'd4);
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      k = (acc < 4) ? acc : 3;
      bus.in_valid = (c % 2 == 0);
      bus.in_a     = t4_a[k];
      bus.in_b     = t4_b[k];
      bus.in_y     = t4_y[k];
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t4_accepts", 32'(acc), 32'd4);
    chk("t4_ready", 32'(bus.in_ready), 32'd0);
    chk("t4_pass_cnt", 32'(pass_cnt), 32'd4);
    chk("t4_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("t4_done", 32'(done), 32'd1);

    // 5: restart mid-run with a beat still in flight
    do_start(16'd5);
    send_beat(8'h01, 8'h02, 8'h03);
    send_beat(8'h01, 8'h02, 8'h00);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("t5_pre_fail_seen", 32'(fail_seen), 32'd1);
    chk("t5_pre_pass_cnt", 32'(pass_cnt), 32'd1);
    send_beat(8'h10, 8'h01, 8'h00);
    do_start(16'd5);
    chk("t5_clr_pass", 32'(pass_cnt), 32'd0);
    chk("t5_clr_fail", 32'(fail_cnt), 32'd0);
    chk("t5_clr_seen", 32'(fail_seen), 32'd0);
    tick();
    tick();
    chk("t5_flushed_fail", 32'(fail_cnt), 32'd0);
    for (int i = 0; i < 5; i++) send_beat(t5_a[i], t5_b[i], t5_y[i]);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("t5_pass_cnt", 32'(pass_cnt), 32'd5);
    chk("t5_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("t5_all_pass", 32'(all_pass), 32'd1);

    // 6: reset during DRAIN clears everything, pipe included
    do_start(16'd2);
    send_beat(8'h01, 8'h01, 8'h01);
    send_beat(8'h02, 8'h00, 8'h02);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_all_pass", 32'(all_pass), 32'd0);
    chk("t6_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_ready_idle", 32'(bus.in_ready), 32'd0);
    chk("t6_no_leak", 32'(pass_cnt), 32'd0);
    chk("t6_done_idle", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
